// File: rtl/countup_timer.sv
// Programmable up-counting timer: Q runs 0..term then wraps, with a tick pulse and sticky done.
// Optional prescaler enabled by defining COUNTUP_PRESCALE_EN.
module countup_timer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] D,
  input  logic             ack,
  output logic [WIDTH-1:0] Q,
  output logic             tick,
  output logic             done,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   term_q, term_d;
  logic               mode_q, mode_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic               step;
  logic               terminal;

`ifdef COUNTUP_PRESCALE_EN
  localparam int unsigned PscW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PscW-1:0] PscLast = PscW'(PRESCALE - 1);

  logic [PscW-1:0] psc_q, psc_d;

  // Only enabled cycles in RUN advance the prescaler; start/stop realign it.
  always_comb begin
    psc_d = psc_q;
    step  = 1'b0;
    if (stop || start) begin
      psc_d = '0;
    end else if (state_q == StRun && en) begin
      if (psc_q == PscLast) begin
        psc_d = '0;
        step  = 1'b1;
      end else begin
        psc_d = psc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end
`else
  always_comb begin
    step = en;
  end
`endif

  assign terminal = (q_q == term_q);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    term_d  = term_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    done_d  = done_q;

    if (ack) begin
      done_d = 1'b0;
    end

    if (stop) begin
      state_d = StIdle;
      q_d     = '0;
    end else if (start) begin
      state_d = StRun;
      term_d  = D;
      mode_d  = oneshot;
      q_d     = '0;
    end else if (state_q == StRun && step) begin
      if (terminal) begin
        // Wrap through the terminal path; a set of done overrides a same-cycle ack.
        q_d    = '0;
        tick_d = 1'b1;
        done_d = 1'b1;
        if (mode_q) begin
          state_d = StIdle;
        end
      end else begin
        q_d = q_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      q_q     <= '0;
      term_q  <= '0;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      term_q  <= term_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign Q    = q_q;
  assign tick = tick_q;
  assign done = done_q;
  assign busy = (state_q == StRun);

endmodule
